// File: rtl/mips_pkg.sv
// Shared types for the MIPS image-processing pipeline: ALU opcodes, forwarding
// selects, multiplier FSM states and a saturating byte-add helper.
package mips_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 6;

  typedef enum logic [2:0] {
    ALU_AND     = 3'b000,
    ALU_OR      = 3'b001,
    ALU_ADD     = 3'b010,
    ALU_MUL     = 3'b011,
    ALU_ADDSAT8 = 3'b100,
    ALU_SRL     = 3'b101,
    ALU_SUB     = 3'b110,
    ALU_SLT     = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

  // Unsigned byte add clamped to 0xFF on carry-out.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs, forwarding/writeback inputs and EX/MEM outputs of the EX stage.
interface execute_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6
);
  logic              RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0]        ALUControlE;
  logic [DATA_W-1:0] RD1E, RD2E, SignImmE, ResultW;
  logic [ADDR_W-1:0] RsE, RtE, RdE;
  logic [1:0]        ForwardAE, ForwardBE;

  logic              BusyE;
  logic [ADDR_W-1:0] WriteRegE;
  logic              RegWriteM, MemtoRegM, MemWriteM;
  logic [DATA_W-1:0] ALUOutM, WriteDataM;
  logic [ADDR_W-1:0] WriteRegM;

  modport master (
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           RD1E, RD2E, SignImmE, ResultW, RsE, RtE, RdE, ForwardAE, ForwardBE,
    input  BusyE, WriteRegE, RegWriteM, MemtoRegM, MemWriteM, ALUOutM,
           WriteDataM, WriteRegM
  );

  modport slave (
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           RD1E, RD2E, SignImmE, ResultW, RsE, RtE, RdE, ForwardAE, ForwardBE,
    output BusyE, WriteRegE, RegWriteM, MemtoRegM, MemWriteM, ALUOutM,
           WriteDataM, WriteRegM
  );
endinterface

// File: rtl/execute_stage_mul_iter.sv
// Iterative shift-add multiplier: latches operands on start, one step per cycle,
// presents the low DATA_W product bits for one DONE cycle.
module mul_iter
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  mul_state_t        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy    = 1'b1;
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Stall request must drop as soon as reset is applied, even combinationally.
    if (rst) busy = 1'b0;
  end

  assign product = acc_q;

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, destination select, ALU with iterative multiply,
// and the EX/MEM pipeline register.
module execute_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic           clk,
  input  logic           CLR,
  execute_stage_if.slave bus
);

  localparam int unsigned SH_W  = $clog2(DATA_W);
  localparam int unsigned LANES = DATA_W / 8;

  logic [DATA_W-1:0] src_a, fwd_b, src_b, alu_res, mul_product;
  logic              mul_start, mul_busy, mul_done;
  logic [ADDR_W-1:0] write_reg_e;

  logic              reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d, write_data_q, write_data_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;

  // Forwarding muxes; select 11 falls back to the register file.
  always_comb begin
    src_a = bus.RD1E;
    case (bus.ForwardAE)
      FWD_W:   src_a = bus.ResultW;
      FWD_M:   src_a = alu_out_q;
      default: src_a = bus.RD1E;
    endcase
    fwd_b = bus.RD2E;
    case (bus.ForwardBE)
      FWD_W:   fwd_b = bus.ResultW;
      FWD_M:   fwd_b = alu_out_q;
      default: fwd_b = bus.RD2E;
    endcase
    src_b       = bus.ALUSrcE ? bus.SignImmE : fwd_b;
    write_reg_e = bus.RegDstE ? bus.RdE : bus.RtE;
  end

  always_comb begin
    alu_res = '0;
    case (alu_op_t'(bus.ALUControlE))
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_ADD: alu_res = src_a + src_b;
      ALU_SUB: alu_res = src_a - src_b;
      ALU_SLT: alu_res = DATA_W'($signed(src_a) < $signed(src_b));
      ALU_SRL: alu_res = src_a >> src_b[SH_W-1:0];
      ALU_ADDSAT8: begin
        for (int i = 0; i < int'(LANES); i++) begin
          alu_res[8*i +: 8] = sat_add8(src_a[8*i +: 8], src_b[8*i +: 8]);
        end
      end
      ALU_MUL: alu_res = mul_done ? mul_product : '0;
      default: alu_res = '0;
    endcase
  end

  assign mul_start = (alu_op_t'(bus.ALUControlE) == ALU_MUL);

  mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (CLR),
    .start   (mul_start),
    .a       (src_a),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // EX/MEM loads every cycle; control bits become a bubble during a stall.
  always_comb begin
    reg_write_d  = bus.RegWriteE & ~mul_busy;
    mem_to_reg_d = bus.MemtoRegE & ~mul_busy;
    mem_write_d  = bus.MemWriteE & ~mul_busy;
    alu_out_d    = alu_res;
    write_data_d = fwd_b;
    write_reg_d  = write_reg_e;
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_out_q    <= '0;
      write_data_q <= '0;
      write_reg_q  <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      alu_out_q    <= alu_out_d;
      write_data_q <= write_data_d;
      write_reg_q  <= write_reg_d;
    end
  end

  assign bus.BusyE      = mul_busy;
  assign bus.WriteRegE  = write_reg_e;
  assign bus.RegWriteM  = reg_write_q;
  assign bus.MemtoRegM  = mem_to_reg_q;
  assign bus.MemWriteM  = mem_write_q;
  assign bus.ALUOutM    = alu_out_q;
  assign bus.WriteDataM = write_data_q;
  assign bus.WriteRegM  = write_reg_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases plus random non-MUL ops against an
// arithmetic reference model, multiply latency/stall and mid-multiply clear.
module tb_execute_stage;
  import mips_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;

  logic clk = 1'b0;
  logic CLR;
  always #5 clk = ~clk;

  execute_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  execute_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .CLR(CLR), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] model_m;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    int s;
    r = '0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: r = a + b;
      3'b110: r = a - b;
      3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101: r = a >> b[4:0];
      3'b100: begin
        for (int i = 0; i < 4; i++) begin
          s = int'(a[8*i +: 8]) + int'(b[8*i +: 8]);
          if (s > 255) s = 255;
          r[8*i +: 8] = 8'(s);
        end
      end
      default: begin
        p = 64'(a) * 64'(b);
        r = p[31:0];
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] w, input logic [31:0] m);
    if (sel == 2'd1) return w;
    if (sel == 2'd2) return m;
    return rf;
  endfunction

  task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] fa, input logic [1:0] fb, input logic alusrc,
                        input logic [31:0] imm, input logic regdst, input logic [5:0] rt,
                        input logic [5:0] rd, input logic rw, input logic mtr,
                        input logic mw, input logic [31:0] resw);
    bus.ALUControlE = op;   bus.RD1E = a;        bus.RD2E = b;
    bus.ForwardAE = fa;     bus.ForwardBE = fb;  bus.ALUSrcE = alusrc;
    bus.SignImmE = imm;     bus.RegDstE = regdst;
    bus.RsE = 6'd1;         bus.RtE = rt;        bus.RdE = rd;
    bus.RegWriteE = rw;     bus.MemtoRegE = mtr; bus.MemWriteE = mw;
    bus.ResultW = resw;
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    set_op(3'b011, 32'd3, 32'd4, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b1, 32'd0);
    #3;
    checks++;
    if (bus.BusyE !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.BusyE); end
    checks++;
    if ({bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM});
    end
    checks++;
    if ({bus.ALUOutM, bus.WriteDataM, bus.WriteRegM} !== '0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h expected 0", bus.ALUOutM, bus.WriteDataM, bus.WriteRegM);
    end
    set_op(3'b000, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    CLR = 1'b0;
    model_m = '0;
  endtask

  task automatic test_directed();
    // ADD 5+7 into rd=9
    set_op(3'b010, 32'd5, 32'd7, 2'd0, 2'd0, 1'b0, 32'd0, 1'b1, 6'd3, 6'd9, 1'b1, 1'b0, 1'b0, 32'd0);
    #1;
    checks++;
    if (bus.WriteRegE !== 6'd9) begin errors++; $display("FAIL add_wrege: got %0d expected 9", bus.WriteRegE); end
    @(posedge clk); #1;
    checks++;
    if (bus.ALUOutM !== 32'd12) begin errors++; $display("FAIL add_out: got %h expected 12", bus.ALUOutM); end
    checks++;
    if (bus.WriteRegM !== 6'd9 || bus.RegWriteM !== 1'b1) begin
      errors++; $display("FAIL add_dest: got reg %0d rw %b expected 9 1", bus.WriteRegM, bus.RegWriteM);
    end
    // ADD 3+4, then SUB forwarding A from EX/MEM and B from writeback
    set_op(3'b010, 32'd3, 32'd4, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0, 6'd4, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    set_op(3'b110, 32'd0, 32'h55, 2'd2, 2'd1, 1'b1, 32'd2, 1'b0, 6'd4, 6'd0, 1'b0, 1'b0, 1'b1, 32'hAA);
    @(posedge clk); #1;
    checks++;
    if (bus.ALUOutM !== 32'd5) begin errors++; $display("FAIL fwd_sub: got %h expected 5", bus.ALUOutM); end
    checks++;
    if (bus.WriteDataM !== 32'hAA) begin errors++; $display("FAIL fwd_wdata: got %h expected aa", bus.WriteDataM); end
    checks++;
    if ({bus.RegWriteM, bus.MemWriteM} !== 2'b01) begin
      errors++; $display("FAIL sub_ctrl: got %b expected 01", {bus.RegWriteM, bus.MemWriteM});
    end
    set_op(3'b100, 32'h10F0FF01, 32'h10200102, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0, 6'd4, 6'd0, 1'b1, 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    checks++;
    if (bus.ALUOutM !== 32'h20FFFF03) begin errors++; $display("FAIL addsat8: got %h expected 20ffff03", bus.ALUOutM); end
    checks++;
    if (bus.MemtoRegM !== 1'b1) begin errors++; $display("FAIL addsat8_mtr: got %b expected 1", bus.MemtoRegM); end
    set_op(3'b111, 32'hFFFFFFFF, 32'd1, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0, 6'd4, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    checks++;
    if (bus.ALUOutM !== 32'd1) begin errors++; $display("FAIL slt: got %h expected 1", bus.ALUOutM); end
    model_m = 32'd1;
  endtask

  task automatic test_random();
    logic [2:0] ops [7] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    logic [2:0] op;
    logic [31:0] a, b, imm, resw, sa, wd, exp;
    logic [1:0] fa, fb;
    logic alusrc, regdst, rw, mtr, mw;
    logic [5:0] rt, rd, exp_wr;
    for (int n = 0; n < 200; n++) begin
      op = ops[$urandom_range(0, 6)];
      a = $urandom; b = $urandom; imm = $urandom; resw = $urandom;
      fa = 2'($urandom); fb = 2'($urandom);
      alusrc = 1'($urandom); regdst = 1'($urandom);
      rw = 1'($urandom); mtr = 1'($urandom); mw = 1'($urandom);
      rt = 6'($urandom); rd = 6'($urandom);
      sa = ref_fwd(fa, a, resw, model_m);
      wd = ref_fwd(fb, b, resw, model_m);
      exp = ref_alu(op, sa, alusrc ? imm : wd);
      exp_wr = regdst ? rd : rt;
      set_op(op, a, b, fa, fb, alusrc, imm, regdst, rt, rd, rw, mtr, mw, resw);
      #1;
      checks++;
      if (bus.BusyE !== 1'b0 || bus.WriteRegE !== exp_wr) begin
        errors++; $display("FAIL rnd_comb[%0d]: got busy %b wreg %0d expected 0 %0d", n, bus.BusyE, bus.WriteRegE, exp_wr);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.ALUOutM !== exp) begin
        errors++; $display("FAIL rnd_alu[%0d] op %b: got %h expected %h", n, op, bus.ALUOutM, exp);
      end
      checks++;
      if (bus.WriteDataM !== wd || bus.WriteRegM !== exp_wr) begin
        errors++; $display("FAIL rnd_wdata[%0d]: got %h/%0d expected %h/%0d", n, bus.WriteDataM, bus.WriteRegM, wd, exp_wr);
      end
      checks++;
      if ({bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM} !== {rw, mtr, mw}) begin
        errors++; $display("FAIL rnd_ctrl[%0d]: got %b expected %b", n, {bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}, {rw, mtr, mw});
      end
      model_m = exp;
    end
  endtask

  // Runs one MUL from its IDLE cycle to the edge that loads the product.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        output int done_cyc);
    int busy_cnt;
    busy_cnt = 0;
    done_cyc = 0;
    set_op(3'b011, a, b, 2'd0, 2'd0, 1'b0, 32'd0, 1'b1, 6'd2, 6'd5, 1'b1, 1'b1, 1'b1, 32'd0);
    for (int i = 0; i <= 33; i++) begin
      #1;
      if (bus.BusyE === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      if (i < 33) begin
        checks++;
        if ({bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM} !== 3'b000) begin
          errors++; $display("FAIL mul_bubble[%0d]: got %b expected 000", i, {bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM});
        end
      end else begin
        checks++;
        if (bus.ALUOutM !== exp) begin errors++; $display("FAIL mul_result: got %h expected %h", bus.ALUOutM, exp); end
        checks++;
        if ({bus.RegWriteM, bus.WriteRegM} !== {1'b1, 6'd5}) begin
          errors++; $display("FAIL mul_dest: got %b/%0d expected 1/5", bus.RegWriteM, bus.WriteRegM);
        end
        done_cyc = cyc;
      end
      if (i < 32) begin
        bus.ResultW = $urandom; bus.RD1E = $urandom;
        bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom);
      end
    end
    checks++;
    if (busy_cnt != 33) begin errors++; $display("FAIL mul_busy_len: got %0d expected 33", busy_cnt); end
    model_m = exp;
  endtask

  task automatic test_mul();
    int c;
    do_mul(32'h00001234, 32'h00000100, 32'h00123400, c);
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, c1);
    do_mul(32'd3, 32'd5, 32'h0000000F, c2);
    checks++;
    if (c2 - c1 != 34) begin errors++; $display("FAIL b2b_spacing: got %0d expected 34", c2 - c1); end
  endtask

  task automatic test_clr_midrun();
    int c;
    set_op(3'b011, 32'h1234, 32'hFFFF, 2'd0, 2'd0, 1'b0, 32'd0, 1'b1, 6'd2, 6'd7, 1'b1, 1'b1, 1'b1, 32'd0);
    repeat (11) @(posedge clk);
    #1;
    checks++;
    if (bus.BusyE !== 1'b1) begin errors++; $display("FAIL clr_pre_busy: got %b expected 1", bus.BusyE); end
    CLR = 1'b1;
    #1;
    checks++;
    if (bus.BusyE !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b expected 0", bus.BusyE); end
    checks++;
    if ({bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM, bus.ALUOutM, bus.WriteDataM, bus.WriteRegM} !== '0) begin
      errors++; $display("FAIL clr_exmem: got %h/%h/%0d expected 0", bus.ALUOutM, bus.WriteDataM, bus.WriteRegM);
    end
    set_op(3'b010, 32'd2, 32'd3, 2'd0, 2'd0, 1'b0, 32'd0, 1'b0, 6'd6, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    #2;
    CLR = 1'b0;
    #1;
    checks++;
    if (bus.BusyE !== 1'b0) begin errors++; $display("FAIL clr_post_busy: got %b expected 0", bus.BusyE); end
    @(posedge clk); #1;
    checks++;
    if (bus.ALUOutM !== 32'd5 || bus.RegWriteM !== 1'b1 || bus.WriteRegM !== 6'd6) begin
      errors++; $display("FAIL clr_post_add: got %h/%b/%0d expected 5/1/6", bus.ALUOutM, bus.RegWriteM, bus.WriteRegM);
    end
    do_mul(32'd7, 32'd9, 32'd63, c);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mul();
    test_back_to_back();
    test_clr_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the MIPS image-processing pipeline, fed by the ID/EX pipeline register and driving the EX/MEM register, which is built into this block. It resolves operand forwarding, selects the destination register, evaluates the ALU, and runs an iterative multiplier. While a multiply is in progress it asserts a stall request toward the hazard unit.

## Interface
- DATA_W, 32, datapath width; must be a multiple of 8 and ≥ 8
- ADDR_W, 6, register-index width
- clk  in  1  pipeline clock, rising edge
- CLR  in  1  reset; asynchronous, active-high
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  in  1 each  control bits from ID/EX
- ALUControlE  in  3  ALU operation (alu_op_t)
- RD1E, RD2E  in  DATA_W  register-file operands from ID/EX
- RsE, RtE, RdE  in  ADDR_W  register indices from ID/EX
- SignImmE  in  DATA_W  extended immediate
- ForwardAE, ForwardBE  in  2  forwarding selects from hazard unit
- ResultW  in  DATA_W  writeback result
- BusyE  out  1  stall request; hazard unit must hold IF/ID and ID/EX while high
- WriteRegE  out  ADDR_W  combinational destination index, for hazard detection
- RegWriteM, MemtoRegM, MemWriteM  out  1 each  EX/MEM control
- ALUOutM  out  DATA_W  EX/MEM result; also the forwarding source
- WriteDataM  out  DATA_W  EX/MEM store data
- WriteRegM  out  ADDR_W  EX/MEM destination index

## Operation
- Forwarding select values:
  - 00 selects RD1E/RD2E.
  - 01 selects ResultW.
  - 10 selects ALUOutM.
  - 11 is treated as 00.
- Operands: SrcA = forwarded A. SrcB = ALUSrcE ? SignImmE : forwarded B. WriteDataE = forwarded B.
- WriteRegE = RegDstE ? RdE : RtE.
- ALU ops:
  - 000 AND, 001 OR, 010 ADD, 110 SUB (all modulo 2^DATA_W).
  - 111 SLT: signed compare, result 1 or 0, zero-extended.
  - 101 SRL: SrcA >> SrcB[log2(DATA_W)-1:0].
  - 100 ADDSAT8: per-byte unsigned add; each lane clamps to 0xFF.
  - 011 MUL: low DATA_W bits of SrcA*SrcB, computed iteratively.
- Multiplier FSM:
  - IDLE: when ALUControlE==MUL, BusyE=1 (combinational), latch SrcA/SrcB, clear accumulator, count=0, go to RUN.
  - RUN: one shift-add step per cycle; BusyE=1. After DATA_W steps, go to DONE.
  - DONE: BusyE=0, ALU result = product; EX/MEM captures it at this edge; go to IDLE.
- Operands are latched in the IDLE cycle. Changes on RD1E/RD2E, forwarding inputs or ResultW during RUN are ignored.
- While BusyE=1, EX/MEM loads a bubble: RegWriteM=0, MemWriteM=0, MemtoRegM=0. The other EX/MEM fields are don't-care; the bench does not check them.
- Non-MUL ops never assert BusyE. EX/MEM loads every cycle.

## Timing
- Non-MUL: one-cycle latency. EX/MEM holds the result after the first rising edge.
- MUL:
  - BusyE is high for DATA_W+1 cycles (the IDLE cycle plus DATA_W RUN cycles).
  - The result reaches EX/MEM at the edge ending the DONE cycle, DATA_W+2 edges after the MUL first appears.
- Back-to-back MULs: the hazard unit advances ID/EX at the DONE edge. The following MUL is seen in IDLE on the next cycle; no gap is required.
- CLR asserted, at any time including mid-multiply:
  - All EX/MEM outputs go to 0 and the FSM goes to IDLE.
  - BusyE is forced to 0 while CLR is high.
  - A partial product is discarded.
- Reset values: RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM all 0. BusyE is 0.

## Structure
- Shared package mips_pkg holds:
  - alu_op_t: the 3-bit enum above.
  - fwd_sel_t: FWD_RF=00, FWD_W=01, FWD_M=10.
  - mul_state_t: IDLE, RUN, DONE.
- One sub-module, mul_iter, contains:
  - The FSM, operand latches, accumulator and step counter.
  - Ports start, a, b, busy, done, product.
- Forwarding, ALU and the EX/MEM register stay in execute_stage.

## Test plan
- ADD with RD1E=5, RD2E=7, ALUSrcE=0, RegDstE=1, RdE=9 -> after 1 edge: ALUOutM=12, WriteRegM=9, RegWriteM passed through.
- ForwardAE=10 with the previous op ADD 3+4 in flight, RD1E=0, SUB with SrcB=2 -> ALUOutM=5. ForwardBE=01 with ResultW=0xAA -> WriteDataM=0xAA.
- ADDSAT8 0x10F0FF01 + 0x10200102 -> 0x20FFFF03. SLT with -1 vs 1 -> 1.
- MUL 0x0000_1234 * 0x0000_0100 -> BusyE high for 33 cycles, EX/MEM bubbles during the stall, then ALUOutM=0x0012_3400. Toggling ResultW mid-run has no effect.
- MUL 0xFFFF_FFFF * 0xFFFF_FFFF followed immediately by MUL 3*5 -> results 0x0000_0001 then 0x0000_000F, 34 edges apart.
- CLR pulsed at RUN step 10 -> BusyE=0 and all EX/MEM outputs 0 immediately. After release, a non-MUL op completes normally in 1 cycle.
